io_timer: RTL and testbench

- 16-bit programmable down-counter with 8-bit prescaler and interrupt request.
- Sits on the I/O side of the SoC as a responder on the CPU's split even/odd byte bus. It sees the same read/write address, data and enable lines the CPU drives.
- The system address decode gates its write enables and muxes its read data.
- Read data is registered: 1-cycle latency, matching the memory responders.

---
 rtl/io_timer.sv | 131 +++++++++++++
 tb/tb_io_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_timer.sv
// io_timer: 16-bit prescaled down-counter on the split even/odd byte bus.
// Registered read data (1-cycle latency) and a registered level interrupt.
module io_timer #(
  parameter logic [15:0] BASEADDR      = 16'h0010,
  parameter logic [7:0]  RESETPRESCALE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] read_addr_even,
  input  logic [14:0] read_addr_odd,
  input  logic [14:0] write_addr_even,
  input  logic [14:0] write_addr_odd,
  input  logic        write_en_even,
  input  logic        write_en_odd,
  input  logic [7:0]  write_data_even,
  input  logic [7:0]  write_data_odd,
  output logic [7:0]  read_data_even,
  output logic [7:0]  read_data_odd,
  output logic        interrupt
);

  localparam logic [12:0] BASE_HI = BASEADDR[15:3];

  logic        en, auto_mode, ie, expired;
  logic [15:0] reload, count;
  logic [7:0]  prescale, pcnt, hi_shadow;

  logic       re_hit_even, re_hit_odd, we_hit_even, we_hit_odd;
  logic [1:0] re_idx_even, re_idx_odd, we_idx_even, we_idx_odd;
  logic       wr_ctrl, wr_reload_lo, wr_reload_hi, wr_prescale, wr_status;
  logic       rd_count_lo, tick, run;
  logic [7:0] rd_next_even, rd_next_odd;

  assign re_hit_even = (read_addr_even[14:2]  == BASE_HI);
  assign re_hit_odd  = (read_addr_odd[14:2]   == BASE_HI);
  assign we_hit_even = (write_addr_even[14:2] == BASE_HI);
  assign we_hit_odd  = (write_addr_odd[14:2]  == BASE_HI);
  assign re_idx_even = read_addr_even[1:0];
  assign re_idx_odd  = read_addr_odd[1:0];
  assign we_idx_even = write_addr_even[1:0];
  assign we_idx_odd  = write_addr_odd[1:0];

  assign wr_ctrl      = write_en_even && we_hit_even && (we_idx_even == 2'd0);
  assign wr_reload_lo = write_en_even && we_hit_even && (we_idx_even == 2'd1);
  assign wr_prescale  = write_en_even && we_hit_even && (we_idx_even == 2'd3);
  assign wr_status    = write_en_odd  && we_hit_odd  && (we_idx_odd  == 2'd0);
  assign wr_reload_hi = write_en_odd  && we_hit_odd  && (we_idx_odd  == 2'd1);

  assign rd_count_lo = re_hit_even && (re_idx_even == 2'd2);
  assign tick        = (pcnt == prescale);
  // A CTRL write clearing EN freezes counting in the same edge, swallowing any tick.
  assign run         = en && !(wr_ctrl && !write_data_even[0]);

  always_comb begin
    rd_next_even = '0;
    if (re_hit_even) begin
      unique case (re_idx_even)
        2'd0: rd_next_even = {5'b0, ie, auto_mode, en};
        2'd1: rd_next_even = reload[7:0];
        2'd2: rd_next_even = count[7:0];
        2'd3: rd_next_even = prescale;
      endcase
    end
  end

  always_comb begin
    rd_next_odd = '0;
    if (re_hit_odd) begin
      unique case (re_idx_odd)
        2'd0: rd_next_odd = {7'b0, expired};
        2'd1: rd_next_odd = reload[15:8];
        // Same-cycle LO read supplies the live HI byte so the pair stays coherent.
        2'd2: rd_next_odd = rd_count_lo ? count[15:8] : hi_shadow;
        2'd3: rd_next_odd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en             <= 1'b0;
      auto_mode      <= 1'b0;
      ie             <= 1'b0;
      expired        <= 1'b0;
      reload         <= '0;
      count          <= '0;
      prescale       <= RESETPRESCALE;
      pcnt           <= '0;
      hi_shadow      <= '0;
      read_data_even <= '0;
      read_data_odd  <= '0;
      interrupt      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en        <= write_data_even[0];
        auto_mode <= write_data_even[1];
        ie        <= write_data_even[2];
        if (write_data_even[0] && !en) begin
          count <= reload;
          pcnt  <= '0;
        end
      end
      if (wr_reload_lo) reload[7:0]  <= write_data_even;
      if (wr_reload_hi) reload[15:8] <= write_data_odd;
      if (wr_prescale)  prescale     <= write_data_even;
      if (wr_status && write_data_odd[0]) expired <= 1'b0;

      // Expiry is evaluated after the CTRL/STATUS writes so it wins both conflicts.
      if (run) begin
        if (tick) begin
          pcnt <= '0;
          if (count != 16'd0) begin
            count <= count - 16'd1;
          end else begin
            expired <= 1'b1;
            if (auto_mode) count <= reload;
            else           en    <= 1'b0;
          end
        end else begin
          pcnt <= pcnt + 8'd1;
        end
      end

      if (rd_count_lo) hi_shadow <= count[15:8];
      read_data_even <= rd_next_even;
      read_data_odd  <= rd_next_odd;
      interrupt      <= expired & ie;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: stimulus queues expected bytes per cycle,
// a negedge monitor pops and compares them against the registered outputs.
module tb_io_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
  logic        write_en_even, write_en_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic [7:0]  read_data_even, read_data_odd;
  logic        interrupt;

  localparam int W = 8;  // BASEADDR/2

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } sb_item_t;

  sb_item_t sbq[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int auto_cnt [23] = '{1,1,1,0,0,0,1,1,1,0,0,0,1,1,1,0,0,0,1,1,1,1,1};
  int auto_exp [23] = '{0,0,0,0,0,0,1,1,0,0,0,0,1,0,0,0,0,0,1,1,1,1,0};

  io_timer #(.BASEADDR(16'h0010), .RESETPRESCALE(8'h5A)) dut (
    .clk(clk),
    .reset(reset),
    .read_addr_even(read_addr_even),
    .read_addr_odd(read_addr_odd),
    .write_addr_even(write_addr_even),
    .write_addr_odd(write_addr_odd),
    .write_en_even(write_en_even),
    .write_en_odd(write_en_odd),
    .write_data_even(write_data_even),
    .write_data_odd(write_data_odd),
    .read_data_even(read_data_even),
    .read_data_odd(read_data_odd),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_rd(input int e, input int o);
    read_addr_even = 15'(W + e);
    read_addr_odd  = 15'(W + o);
  endtask

  task automatic wr_e(input int off, input logic [7:0] d);
    write_en_even   = 1'b1;
    write_addr_even = 15'(W + off);
    write_data_even = d;
  endtask

  task automatic wr_o(input int off, input logic [7:0] d);
    write_en_odd   = 1'b1;
    write_addr_odd = 15'(W + off);
    write_data_odd = d;
  endtask

  // sig: 0 read_data_even, 1 read_data_odd, 2 interrupt; checked next cycle.
  task automatic push(input int sig, input logic [7:0] v, input string n);
    sb_item_t t;
    t.cyc  = cyc + 1;
    t.sig  = sig;
    t.val  = v;
    t.name = n;
    sbq.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    write_en_even = 1'b0;
    write_en_odd  = 1'b0;
    set_rd(-8, -8);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        sb_item_t t;
        logic [7:0] act;
        t = sbq.pop_front();
        case (t.sig)
          0:       act = read_data_even;
          1:       act = read_data_odd;
          default: act = {7'b0, interrupt};
        endcase
        n_checks++;
        if (act !== t.val) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %02h expected %02h", t.name, cyc, act, t.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    write_en_even = 1'b0;
    write_en_odd = 1'b0;
    write_addr_even = '0;
    write_addr_odd = '0;
    write_data_even = '0;
    write_data_odd = '0;
    set_rd(-8, -8);
    repeat (3) step();
    reset = 1'b0;

    // Reset state of every offset
    set_rd(0, 0); push(0, 8'h00, "rst_ctrl"); push(1, 8'h00, "rst_status"); push(2, 8'h00, "rst_irq"); step();
    set_rd(1, 1); push(0, 8'h00, "rst_reload_lo"); push(1, 8'h00, "rst_reload_hi"); step();
    set_rd(2, 2); push(0, 8'h00, "rst_count_lo"); push(1, 8'h00, "rst_count_hi"); step();
    set_rd(3, 3); push(0, 8'h5A, "rst_prescale"); push(1, 8'h00, "rst_reserved"); step();
    set_rd(4, -1); push(0, 8'h00, "oow_read_even"); push(1, 8'h00, "oow_read_odd"); step();

    // One-shot: RELOAD=3, PRESCALE=0, CTRL=EN|IE
    wr_e(1, 8'h03); wr_o(1, 8'h00); step();
    wr_e(3, 8'h00); step();
    wr_e(0, 8'h05); set_rd(2, -8); push(0, 8'h00, "oneshot_pre"); step();
    for (int i = 0; i < 4; i++) begin
      set_rd(2, 0);
      push(0, 8'(3 - i), "oneshot_count");
      push(1, 8'h00, "oneshot_exp_low");
      push(2, 8'h00, "oneshot_irq_low");
      step();
    end
    set_rd(0, 0); push(0, 8'h04, "oneshot_ctrl"); push(1, 8'h01, "oneshot_exp"); push(2, 8'h01, "oneshot_irq"); step();
    set_rd(2, 0); wr_o(0, 8'h00); push(0, 8'h00, "oneshot_hold"); push(1, 8'h01, "status_w0"); step();
    set_rd(-8, 0); wr_o(0, 8'h01); push(1, 8'h01, "status_preclear"); step();
    set_rd(-8, 0); push(1, 8'h00, "status_cleared"); push(2, 8'h00, "irq_cleared"); step();

    // Auto-reload: RELOAD=1, PRESCALE=2, CTRL=EN|AUTO -> period 6
    wr_e(1, 8'h01); step();
    wr_e(3, 8'h02); step();
    wr_e(0, 8'h03); step();
    for (int i = 0; i < 23; i++) begin
      set_rd(2, 0);
      push(0, 8'(auto_cnt[i]), "auto_count");
      push(1, 8'(auto_exp[i]), "auto_exp");
      push(2, 8'h00, "auto_irq");
      if (i == 7 || i == 12 || i == 17 || i == 21) wr_o(0, 8'h01);
      if (i == 20) wr_e(0, 8'h00);
      step();
    end

    // Atomic COUNT read: COUNT=0x0100, PRESCALE=0
    wr_e(1, 8'h00); wr_o(1, 8'h01); step();
    wr_e(3, 8'h00); step();
    wr_e(0, 8'h01); step();
    set_rd(2, -8); push(0, 8'h00, "atomic_lo"); step();
    set_rd(-8, 2); push(1, 8'h01, "atomic_hi_shadow"); step();
    set_rd(2, 2); push(0, 8'hFE, "dual_lo"); push(1, 8'h00, "dual_hi_live"); step();
    set_rd(-8, 2); push(1, 8'h00, "shadow_refresh"); step();

    // Read returns pre-write value
    wr_e(1, 8'hAA); set_rd(1, -8); push(0, 8'h00, "prewrite_old"); step();
    set_rd(1, -8); push(0, 8'hAA, "prewrite_new"); step();

    // Reset mid-count
    wr_e(0, 8'h00); step();
    wr_e(1, 8'h10); wr_o(1, 8'h00); step();
    wr_e(3, 8'h03); step();
    wr_e(0, 8'h05); step();
    set_rd(2, 2); push(0, 8'h10, "mid_lo"); push(1, 8'h00, "mid_hi"); step();
    reset = 1'b1; step();
    reset = 1'b0;
    set_rd(0, 0); push(0, 8'h00, "rst2_ctrl"); push(1, 8'h00, "rst2_exp"); push(2, 8'h00, "rst2_irq"); step();
    set_rd(1, 1); push(0, 8'h00, "rst2_reload_lo"); push(1, 8'h00, "rst2_reload_hi"); step();
    set_rd(2, 2); push(0, 8'h00, "rst2_count_lo"); push(1, 8'h00, "rst2_count_hi"); step();
    set_rd(3, 3); push(0, 8'h5A, "rst2_prescale"); push(1, 8'h00, "rst2_reserved"); step();
    set_rd(-8, 0); push(1, 8'h00, "rst2_no_exp"); push(2, 8'h00, "rst2_irq_late"); step();

    // Writes outside the window are ignored
    wr_e(4, 8'h07); wr_o(-3, 8'h42); step();
    set_rd(0, 1); push(0, 8'h00, "oow_ctrl"); push(1, 8'h00, "oow_reload_hi"); step();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) step();
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
